reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- 32x32 RV32I integer register file with a per-register pending scoreboard. Sits directly upstream of the ALU.
- rs1_dout/rs2_dout drive the ALU operand muxes; writeback data returns on rd_din.
- The scoreboard tracks destinations of in-flight multi-cycle producers (loads, future M-extension unit) and raises per-operand busy flags so the control unit can stall issue.

Parameters:
- XLEN, 32, data width of each register.
- SP_INIT, 32'h0000_2ffc, reset value of x2 (stack pointer).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the old value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- rs1  input  5  read address, operand 1.
- rs2  input  5  read address, operand 2.
- rs1_dout  output  XLEN  operand 1 data, to ALU alu_in_1 mux.
- rs2_dout  output  XLEN  operand 2 data, to ALU alu_in_2 mux.
- write_enable  input  1  writeback strobe.
- rd  input  5  writeback address.
- rd_din  input  XLEN  writeback data.
- issue_valid  input  1  an instruction with a multi-cycle result issues this cycle.
- issue_rd  input  5  destination of the issuing instruction.
- rs1_busy  output  1  operand 1 not yet available; stall.
- rs2_busy  output  1  operand 2 not yet available; stall.
- issue_stall  output  1  issue_rd already pending; issuer must hold.
- pending_cnt  output  6  number of pending registers (0..31).

Behaviour:
- Reset (clk edge with reset=1):
  - all registers cleared to 0 except x2 = SP_INIT.
  - all pending bits cleared, pending_cnt = 0.
  - write_enable and issue_valid are ignored in that cycle.
- Reset mid-operation discards all pending state; no writeback completes in the reset cycle.
- Reads are combinational, zero latency.
- x0 handling:
  - reads always return 0.
  - writes to x0 are dropped.
  - issue to x0 is ignored and never sets a pending bit.
  - x0 is never busy.
- Writes: at the clk edge with write_enable=1 and rd!=0, reg[rd] <= rd_din and pending[rd] <= 0.
- Bypass (BYPASS=1): if write_enable && rd==rsN && rd!=0, then rsN_dout = rd_din this cycle.
- Busy outputs:
  - rsN_busy = pending[rsN] && !(BYPASS && write_enable && rd==rsN).
  - With BYPASS=0, busy stays 1 through the writeback cycle and clears the next cycle.
- Issue: at the clk edge with issue_valid=1, issue_rd!=0 and issue_stall=0, pending[issue_rd] <= 1.
- issue_stall (combinational) = issue_valid && issue_rd!=0 && pending[issue_rd] && !(write_enable && rd==issue_rd).
  - This blocks WAW with a single pending bit. When stalled, the issue is not recorded.
- Simultaneous writeback and issue to the same register: the write lands and the pending bit ends up set (the new producer wins).
- Writeback to a non-pending register is a plain write; pending is unchanged (stays 0).
- pending_cnt:
  - registered, updated every cycle as +1 (set only), -1 (clear only), or 0 (both, or neither).
  - "Clear" counts only when the bit was actually set.
  - The count never wraps: 31 is the maximum possible since x0 is excluded.
- rs1==rs2 is legal; both ports return identical data and busy.

Decomposition:
- Shared package (riscv_pkg) holds XLEN, REG_ADDR_W=5, NUM_REGS=32, SP_INIT, and the x0 constant.
- One natural sub-module: reg_scoreboard. It owns the pending vector, issue_stall, busy qualification and pending_cnt.
- The top level holds the storage array, reset init and bypass muxes.

Test Plan:
- Reset: assert reset 1 cycle, then read rs1=2, rs2=5 -> rs1_dout=0x00002ffc, rs2_dout=0, pending_cnt=0.
- x0: write_enable=1, rd=0, rd_din=0xDEADBEEF; next cycle rs1=0 -> rs1_dout=0. Also issue_valid=1, issue_rd=0 -> pending_cnt stays 0.
- Bypass (BYPASS=1): write rd=7, rd_din=0x12345678 while rs1=7 -> same-cycle rs1_dout=0x12345678; next cycle still 0x12345678. With BYPASS=0, same-cycle rs1_dout shows the old value 0.
- Scoreboard: issue rd=10, then rs2=10 -> rs2_busy=1, pending_cnt=1. Write rd=10 with 0xA5A5A5A5 -> same cycle rs2_busy=0 and rs2_dout=0xA5A5A5A5; next cycle pending_cnt=0.
- WAW and simultaneous events:
  - With x10 pending, issue rd=10 -> issue_stall=1, pending_cnt stays 1.
  - Same cycle as a writeback to rd=10 -> issue_stall=0; afterwards pending[10]=1, pending_cnt=1, reg[10]=rd_din.
- Reset mid-operation: issue rd=3,4,5 (pending_cnt=3), then assert reset -> next cycle pending_cnt=0, rs1=3 gives busy=0 and dout=0, x2=0x00002ffc.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the register file and its scoreboard.
// Holds the data width, register addressing, the stack-pointer reset value
// and the hard-wired-zero register index.
package riscv_pkg;
  localparam int          XLEN       = 32;
  localparam int          REG_ADDR_W = 5;
  localparam int          NUM_REGS   = 32;
  localparam logic [31:0] SP_INIT    = 32'h0000_2ffc;
  localparam logic [4:0]  X0         = 5'd0;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending scoreboard for multi-cycle producers.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   rs1, rs2              - operand read addresses
//   write_enable, rd      - writeback strobe and address (clears pending)
//   issue_valid, issue_rd - multi-cycle issue and its destination (sets pending)
//   rs1_busy, rs2_busy    - operand not yet available
//   issue_stall           - destination already pending, issuer must hold
//   pending_cnt           - number of pending registers
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  write_enable,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  issue_stall,
  output logic [5:0]            pending_cnt
);

  // Bit 0 is never set because issue to x0 is filtered out.
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;
  logic                wr_hit;
  logic                set_en;
  logic                clr_en;

  assign wr_hit = write_enable && (rd != X0);
  // Only a writeback that actually retires a pending bit decrements the count.
  assign clr_en = wr_hit && pending[rd];

  // A writeback to the same register in this cycle frees the slot, so the
  // new producer may issue instead of stalling.
  assign issue_stall = issue_valid && (issue_rd != X0) && pending[issue_rd] &&
                       !(write_enable && (rd == issue_rd));
  assign set_en = issue_valid && (issue_rd != X0) && !issue_stall;

  assign rs1_busy = pending[rs1] && !((BYPASS != 0) && write_enable && (rd == rs1));
  assign rs2_busy = pending[rs2] && !((BYPASS != 0) && write_enable && (rd == rs2));

  // Issue is applied after the clear so a same-register writeback+issue
  // leaves the bit set (the newer producer wins).
  always_comb begin
    pending_nxt = pending;
    if (wr_hit) pending_nxt[rd] = 1'b0;
    if (set_en) pending_nxt[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending     <= '0;
      pending_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      case ({set_en, clr_en})
        2'b10:   pending_cnt <= pending_cnt + 6'd1;
        2'b01:   pending_cnt <= pending_cnt - 6'd1;
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// 32x32 RV32I integer register file with pending scoreboard.
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   rs1, rs2              - combinational read addresses
//   rs1_dout, rs2_dout    - operand data to the ALU input muxes
//   write_enable, rd, rd_din - writeback port
//   issue_valid, issue_rd - multi-cycle producer issue
//   rs1_busy, rs2_busy, issue_stall, pending_cnt - scoreboard status
module reg_file_sb
  import riscv_pkg::*;
#(
  parameter int                        XLEN    = riscv_pkg::XLEN,
  parameter logic [riscv_pkg::XLEN-1:0] SP_INIT = riscv_pkg::SP_INIT,
  parameter int                        BYPASS  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic [XLEN-1:0]       rs1_dout,
  output logic [XLEN-1:0]       rs2_dout,
  input  logic                  write_enable,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [XLEN-1:0]       rd_din,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  issue_stall,
  output logic [5:0]            pending_cnt
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= (i == 2) ? SP_INIT[XLEN-1:0] : '0;
    end else if (write_enable && (rd != X0)) begin
      regs[rd] <= rd_din;
    end
  end

  // x0 is forced to zero on read; writes to it never land anyway.
  always_comb begin
    rs1_dout = regs[rs1];
    if (rs1 == X0)
      rs1_dout = '0;
    else if ((BYPASS != 0) && write_enable && (rd == rs1))
      rs1_dout = rd_din;
  end

  always_comb begin
    rs2_dout = regs[rs2];
    if (rs2 == X0)
      rs2_dout = '0;
    else if ((BYPASS != 0) && write_enable && (rd == rs2))
      rs2_dout = rd_din;
  end

  reg_scoreboard #(.BYPASS(BYPASS)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .rs1          (rs1),
    .rs2          (rs2),
    .write_enable (write_enable),
    .rd           (rd),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .issue_stall  (issue_stall),
    .pending_cnt  (pending_cnt)
  );

endmodule
